seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Scan scheduler for the four-digit seven-segment display. It holds CPU-written digit, dot and enable registers. It time-multiplexes the single seg7decoder across the enabled digits, inserting a blanking dead time between digits to stop ghosting. It sits between the microprocessor data bus and the seg7decoder inputs (select, BIN, DOT), and adds a BLANK output that the top level uses to force HEX_OUT to 8'hFF.

## Interface
- SCAN_DIV, 25000: clk_sys cycles each digit is lit (SHOW); must be ≥1.
- DEAD_CYCLES, 16: clk_sys cycles blanked before each digit is lit (DEAD); must be ≥1.
- BASE_ADDR, 8'hD0: bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
- clk_sys  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- BUS_ADDR  in  8  CPU write address.
- BUS_DATA  in  8  CPU write data.
- BUS_WE  in  1  write strobe; one write per asserted cycle.
- SEG_SELECT  out  2  digit index to the decoder.
- BIN  out  4  nibble to the decoder.
- DOT  out  1  decimal point to the decoder.
- BLANK  out  1  1 = all digits off.

## Operation
- Registers. Writes land on the clk_sys edge where BUS_WE=1. Writes to any address outside the three below are ignored.
  - BASE+0: digit0 = DATA[3:0], digit1 = DATA[7:4].
  - BASE+1: digit2 = DATA[3:0], digit3 = DATA[7:4].
  - BASE+2: dot_mask = DATA[3:0], en_mask = DATA[7:4].
  - Reset values: digits 0, dot_mask 0, en_mask 4'hF.
- FSM states are OFF, DEAD and SHOW. The reset state is OFF.
  - OFF: BLANK=1. If en_mask≠0, load cur = lowest enabled digit and go to DEAD.
  - DEAD: BLANK=1, SEG_SELECT=cur. Stay DEAD_CYCLES cycles, then go to SHOW.
  - SHOW: BLANK=0. Stay SCAN_DIV cycles, then load cur = next enabled digit and go to DEAD.
- Next-enabled-digit search runs cyclically from cur+1 and wraps 3→0. When only one digit is enabled, the search returns cur, and that digit still passes through DEAD every period.
- If en_mask becomes 0 in any state: go to OFF on the next edge.
- If en_mask[cur] is cleared during DEAD or SHOW: abort at the next edge, load the next enabled digit and restart DEAD.
- A single dwell counter is reloaded on every state entry. Its width is clog2(max(SCAN_DIV, DEAD_CYCLES)+1). It never wraps, because terminal count forces a state change.
- Output sources:
  - BIN = digit[cur] and DOT = dot_mask[cur], registered every cycle. A register write therefore shows up even mid-SHOW.
  - In OFF, BIN and DOT are held at 0.
- Simultaneous write and state transition: the FSM decision in that cycle uses the pre-write register values. The new values take effect from the following cycle.
- Reset mid-operation: the next edge with rst_n=0 returns everything to reset values, with no partial-scan memory.

## Timing
- Reset values of outputs: SEG_SELECT=0, BIN=0, DOT=0, BLANK=1.
- All outputs are registered.
- Write latency:
  - The register updates on the BUS_WE edge (edge N).
  - BIN/DOT reflect the change on edge N+1 if that digit is current.
  - A mask change affects the FSM decision from edge N+1.
- Start-up with reset values:
  - 1 cycle in OFF.
  - Then DEAD_CYCLES cycles with BLANK=1 and SEG_SELECT=0.
  - Then BLANK falls.
- Steady-state period per enabled digit: DEAD_CYCLES + SCAN_DIV cycles.
- Full frame: (number of enabled digits) × (DEAD_CYCLES + SCAN_DIV) cycles.
- SEG_SELECT changes only on the edge entering DEAD, so it is stable for the whole lit interval.

## Test plan
All scenarios use SCAN_DIV=4 and DEAD_CYCLES=2.
- Reset/start-up:
  - Drive rst_n=0 for 3 cycles, then release.
  - Required: BLANK=1 for exactly 3 cycles after release.
  - Then SEG_SELECT sequence 0,1,2,3,0 repeats, with each digit lit 4 cycles and blanked 2 cycles.
- Data/dot:
  - Write BASE+0=8'h8A, BASE+1=8'hC0, BASE+2=8'hF5.
  - Required BIN/DOT during SHOW: sel0 → A/1, sel1 → 8/0, sel2 → 0/1, sel3 → C/0.
- Sparse mask:
  - Write BASE+2 with en_mask=4'b1010.
  - Required: select alternates 1,3,1 with a 6-cycle period each.
  - Then write en_mask=4'b0100. Required: only sel2 is lit, and it repeats 2 blank + 4 lit cycles.
- Disable current digit mid-SHOW:
  - Clear en_mask[cur] on SHOW cycle 2.
  - Required: BLANK=1 on the next edge, and DEAD starts on the next enabled digit.
- All off / re-enable:
  - Write en_mask=0. Required: BLANK=1 on the next edge, and BIN/DOT=0.
  - Then write en_mask=4'b0001. Required: after 1 OFF cycle and 2 DEAD cycles, sel0 is lit.
- Address decode and reset mid-scan:
  - Write BASE+3 and 8'h00. Required: no register changes.
  - Assert rst_n=0 mid-SHOW. Required: outputs return to reset values at the next edge.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit seven-segment scan scheduler with CPU-written registers
//
// Holds digit, dot and enable registers written over a simple write-only bus and
// time-multiplexes one seg7 decoder across the enabled digits, blanking the
// display for a dead time before each digit is lit.
//
// Ports:
//   clk_sys     system clock (single domain)
//   rst_n       synchronous active-low reset
//   BUS_ADDR    CPU write address
//   BUS_DATA    CPU write data
//   BUS_WE      write strobe, one write per asserted cycle
//   SEG_SELECT  digit index to the decoder
//   BIN         nibble to the decoder
//   DOT         decimal point to the decoder
//   BLANK       1 = all digits off
module seg7_scan_ctrl #(
    parameter int         SCAN_DIV    = 25000,
    parameter int         DEAD_CYCLES = 16,
    parameter logic [7:0] BASE_ADDR   = 8'hD0
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [1:0] SEG_SELECT,
    output logic [3:0] BIN,
    output logic       DOT,
    output logic       BLANK
);

    localparam int MAX_DWELL = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CW        = $clog2(MAX_DWELL + 1);

    // The counter holds the remaining cycles minus one; zero is the last cycle.
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LOAD = CW'(SCAN_DIV - 1);

    localparam logic [7:0] ADDR_DIG01 = BASE_ADDR;
    localparam logic [7:0] ADDR_DIG23 = 8'(BASE_ADDR + 8'd1);
    localparam logic [7:0] ADDR_MASK  = 8'(BASE_ADDR + 8'd2);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    logic [15:0]   digits_q;
    logic [3:0]    dot_mask_q;
    logic [3:0]    en_mask_q;

    state_t        state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    sel_q;
    logic [3:0]    bin_q;
    logic          dot_q;
    logic          blank_q;

    // Cyclic search starting at from+1; offset 4 lands on 'from' itself, so a
    // lone enabled digit selects itself. Descending loop lets the nearest win.
    function automatic logic [1:0] next_en(input logic [1:0] from, input logic [3:0] mask);
        logic [1:0] idx;
        next_en = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (mask[idx]) begin
                next_en = idx;
            end
        end
    endfunction

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            digits_q   <= 16'h0000;
            dot_mask_q <= 4'h0;
            en_mask_q  <= 4'hF;
        end else if (BUS_WE) begin
            case (BUS_ADDR)
                ADDR_DIG01: digits_q[7:0]  <= BUS_DATA;
                ADDR_DIG23: digits_q[15:8] <= BUS_DATA;
                ADDR_MASK: begin
                    dot_mask_q <= BUS_DATA[3:0];
                    en_mask_q  <= BUS_DATA[7:4];
                end
                default: ;
            endcase
        end
    end

    // The FSM reads the registered masks, so a write on this edge only
    // influences decisions from the following edge.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (en_mask_q != 4'h0) begin
                    cur_d   = next_en(2'd3, en_mask_q);
                    state_d = ST_DEAD;
                    cnt_d   = DEAD_LOAD;
                end
            end
            ST_DEAD, ST_SHOW: begin
                if (en_mask_q == 4'h0) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (!en_mask_q[cur_q]) begin
                    cur_d   = next_en(cur_q, en_mask_q);
                    state_d = ST_DEAD;
                    cnt_d   = DEAD_LOAD;
                end else if (cnt_q == '0) begin
                    if (state_q == ST_DEAD) begin
                        state_d = ST_SHOW;
                        cnt_d   = SHOW_LOAD;
                    end else begin
                        cur_d   = next_en(cur_q, en_mask_q);
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state the FSM is entering.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cur_q   <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            bin_q   <= 4'h0;
            dot_q   <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            sel_q   <= cur_d;
            blank_q <= (state_d != ST_SHOW);
            if (state_d == ST_OFF) begin
                bin_q <= 4'h0;
                dot_q <= 1'b0;
            end else begin
                bin_q <= digits_q[{cur_d, 2'b00} +: 4];
                dot_q <= dot_mask_q[cur_d];
            end
        end
    end

    assign SEG_SELECT = sel_q;
    assign BIN        = bin_q;
    assign DOT        = dot_q;
    assign BLANK      = blank_q;

endmodule
